// File: rtl/params_pkg.sv
// Shared parameters and state encoding for the instruction fetch path.
package params_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 32;
   localparam int MEM_SIZE   = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_HOLD  = 2'b10,
      ST_FAULT = 2'b11
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives PC to a combinational instruction memory,
// captures one word into the IR per request and holds it until acknowledged.
module fetch_unit
   import params_pkg::*;
#(
   parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
   parameter int MEM_SIZE   = params_pkg::MEM_SIZE,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  fetch_req_i,
   input  logic                  instr_ack_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_instr_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] instr_pc_o,
   output logic                  instr_valid_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  fault_o
);

   // One extra bit so a MEM_SIZE of exactly 2^ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

   fetch_state_e          state_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [DATA_WIDTH-1:0] ir_r;
   logic [ADDR_WIDTH-1:0] instr_pc_r;
   logic                  valid_r;
   logic                  fault_r;

   logic [ADDR_WIDTH-1:0] pc_inc_s;
   logic                  pc_in_range_s;

   // Next sequential PC and range check of the current fetch address.
   always_comb begin
      pc_inc_s      = pc_r + ADDR_WIDTH'(1);
      pc_in_range_s = 1'b0;
      if ({1'b0, pc_r} < MEM_LIMIT) begin
         pc_in_range_s = 1'b1;
      end else begin
         pc_in_range_s = 1'b0;
      end
   end

   // Fetch FSM with PC, IR and status registers; redirect outranks all else.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= ST_IDLE;
         pc_r       <= RESET_PC;
         ir_r       <= '0;
         instr_pc_r <= '0;
         valid_r    <= 1'b0;
         fault_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (redirect_i) begin
                  pc_r <= redirect_pc_i;
               end else if (fetch_req_i) begin
                  if (pc_in_range_s) begin
                     state_r <= ST_FETCH;
                  end else begin
                     state_r <= ST_FAULT;
                     fault_r <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               if (redirect_i) begin
                  pc_r    <= redirect_pc_i;
                  state_r <= ST_IDLE;
                  valid_r <= 1'b0;
               end else begin
                  ir_r       <= imem_instr_i;
                  instr_pc_r <= pc_r;
                  pc_r       <= pc_inc_s;
                  state_r    <= ST_HOLD;
                  valid_r    <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (redirect_i) begin
                  pc_r    <= redirect_pc_i;
                  state_r <= ST_IDLE;
                  valid_r <= 1'b0;
               end else if (instr_ack_i && fetch_req_i) begin
                  state_r <= ST_FETCH;
                  valid_r <= 1'b0;
               end else if (instr_ack_i) begin
                  state_r <= ST_IDLE;
                  valid_r <= 1'b0;
               end
            end
            ST_FAULT: begin
               // Terminal until reset: PC frozen, redirects ignored.
               state_r <= ST_FAULT;
               valid_r <= 1'b0;
               fault_r <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr_o   = pc_r;
   assign pc_o          = pc_r;
   assign instr_o       = ir_r;
   assign instr_pc_o    = instr_pc_r;
   assign instr_valid_o = valid_r;
   assign fault_o       = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, then random traffic
// against a transaction-level reference model.
module tb_fetch_unit;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MS = 128;
   localparam int DEPTH = 1 << AW;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b1;
   logic          fetch_req_i = 1'b0;
   logic          instr_ack_i = 1'b0;
   logic          redirect_i = 1'b0;
   logic [AW-1:0] redirect_pc_i = '0;
   logic [AW-1:0] imem_addr_o;
   logic [DW-1:0] imem_instr_i;
   logic [DW-1:0] instr_o;
   logic [AW-1:0] instr_pc_o;
   logic          instr_valid_o;
   logic [AW-1:0] pc_o;
   logic          fault_o;

   logic [DW-1:0] mem [0:DEPTH-1];

   int errors = 0;
   int checks = 0;

   // Reference model: a fetch is either waiting to be issued, in flight,
   // or delivered and waiting for acknowledge.
   int unsigned   m_pc;
   bit            m_inflight;
   bit            m_valid;
   bit            m_fault;
   logic [DW-1:0] m_ir;
   int unsigned   m_ipc;

   fetch_unit dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .fetch_req_i   (fetch_req_i),
      .instr_ack_i   (instr_ack_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_addr_o   (imem_addr_o),
      .imem_instr_i  (imem_instr_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_valid_o (instr_valid_o),
      .pc_o          (pc_o),
      .fault_o       (fault_o)
   );

   always #5 clk_i = ~clk_i;

   assign imem_instr_i = mem[imem_addr_o];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc       = 0;
      m_inflight = 1'b0;
      m_valid    = 1'b0;
      m_fault    = 1'b0;
      m_ir       = '0;
      m_ipc      = 0;
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, "_pc"},    pc_o,          m_pc);
      check_eq({tag, "_addr"},  imem_addr_o,   m_pc);
      check_eq({tag, "_valid"}, instr_valid_o, m_valid);
      check_eq({tag, "_fault"}, fault_o,       m_fault);
      check_eq({tag, "_instr"}, instr_o,       m_ir);
      check_eq({tag, "_ipc"},   instr_pc_o,    m_ipc);
   endtask

   // One clock: model consumes the inputs presented at the edge, then compare.
   task automatic step(input string tag);
      bit          req, ack, rd;
      int unsigned tgt;
      req = fetch_req_i;
      ack = instr_ack_i;
      rd  = redirect_i;
      tgt = redirect_pc_i;
      @(posedge clk_i);
      if (m_fault) begin
         // nothing changes once faulted
      end else if (rd) begin
         m_pc       = tgt;
         m_inflight = 1'b0;
         m_valid    = 1'b0;
      end else if (m_inflight) begin
         m_ir       = mem[m_pc];
         m_ipc      = m_pc;
         m_pc       = (m_pc + 1) % DEPTH;
         m_inflight = 1'b0;
         m_valid    = 1'b1;
      end else if (m_valid) begin
         if (ack) begin
            m_valid    = 1'b0;
            m_inflight = req;
         end
      end else if (req) begin
         if (m_pc >= MS) m_fault = 1'b1;
         else            m_inflight = 1'b1;
      end
      #1;
      check_all(tag);
   endtask

   // Assert reset between edges, check before any edge, release on a negedge.
   task automatic apply_reset(input string tag);
      #1;
      rst_ni = 1'b0;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[0] = 32'h0000_4470;
      model_reset();

      #1 rst_ni = 1'b0;
      #2 check_all("por");
      fetch_req_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;

      // First request honoured on the first edge after release.
      step("first_req");
      fetch_req_i = 1'b0;
      step("first_load");
      check_eq("w0_valid", instr_valid_o, 1'b1);
      check_eq("w0_instr", instr_o, 32'h0000_4470);
      check_eq("w0_ipc",   instr_pc_o, 8'd0);
      check_eq("w0_pc",    pc_o, 8'd1);
      step("w0_hold");
      check_eq("w0_still_valid", instr_valid_o, 1'b1);

      // Back-to-back fetches with ack and req held high.
      instr_ack_i = 1'b1;
      fetch_req_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step("b2b_fetch");
         step("b2b_load");
         check_eq("b2b_instr", instr_o, mem[k]);
         check_eq("b2b_pc",    pc_o, k + 1);
      end
      fetch_req_i = 1'b0;
      step("b2b_ack");
      instr_ack_i = 1'b0;

      // Redirect during the fetch of word 8 discards it.
      redirect_i = 1'b1; redirect_pc_i = 8'd8;
      step("rd_to8");
      redirect_i = 1'b0; fetch_req_i = 1'b1;
      step("fetch8");
      fetch_req_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 8'd63;
      step("rd_mid_fetch");
      check_eq("rd_ir_kept", instr_o, mem[3]);
      check_eq("rd_valid",   instr_valid_o, 1'b0);
      check_eq("rd_pc",      pc_o, 8'd63);
      redirect_i = 1'b0; fetch_req_i = 1'b1;
      step("fetch63");
      fetch_req_i = 1'b0;
      step("load63");
      check_eq("w63_instr", instr_o, mem[63]);
      check_eq("w63_ipc",   instr_pc_o, 8'd63);
      instr_ack_i = 1'b1;
      step("ack63");
      instr_ack_i = 1'b0;

      // Redirect beats a simultaneous request in IDLE.
      redirect_i = 1'b1; redirect_pc_i = 8'd20; fetch_req_i = 1'b1;
      step("rd_req_idle");
      redirect_i = 1'b0; fetch_req_i = 1'b0;
      check_eq("rdreq_pc", pc_o, 8'd20);
      step("rdreq_nofetch");
      check_eq("rdreq_pc2",   pc_o, 8'd20);
      check_eq("rdreq_valid", instr_valid_o, 1'b0);

      // Out-of-range fetch faults, fault is sticky, reset clears it.
      redirect_i = 1'b1; redirect_pc_i = 8'd128;
      step("rd_128");
      redirect_i = 1'b0; fetch_req_i = 1'b1;
      step("fault_req");
      check_eq("fault_set", fault_o, 1'b1);
      fetch_req_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 8'd5;
      step("fault_rd");
      redirect_i = 1'b0;
      check_eq("fault_sticky", fault_o, 1'b1);
      check_eq("fault_pc",     pc_o, 8'd128);
      apply_reset("fault_rst");
      check_eq("fault_clr", fault_o, 1'b0);
      check_eq("fault_rpc", pc_o, 8'd0);

      // Asynchronous reset mid-HOLD, then no stale IR update.
      fetch_req_i = 1'b1;
      step("h_req");
      fetch_req_i = 1'b0;
      step("h_load");
      apply_reset("hold_rst");
      check_eq("hold_rst_valid", instr_valid_o, 1'b0);
      step("post_rst1");
      step("post_rst2");
      check_eq("post_rst_ir", instr_o, 32'h0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if (m_fault && ($urandom % 4 == 0)) begin
            apply_reset("rnd_rst");
         end
         fetch_req_i = ($urandom % 3) != 0;
         instr_ack_i = $urandom % 2;
         redirect_i  = ($urandom % 12) == 0;
         if ($urandom % 8 == 0) redirect_pc_i = AW'(MS + $urandom % (DEPTH - MS));
         else                   redirect_pc_i = AW'($urandom % MS);
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
